// File: rtl/trap_sequencer.sv
// Trap sequencer: arbitrates faults, software and external interrupts, switches the
// control-register bank between user and supervisor, and restores user context on reti.
module trap_sequencer #(
    parameter logic [15:0] VEC_BASE = 16'h0010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc_in,
    input  logic        instr_done,
    input  logic        reti,
    input  logic        swi,
    input  logic        pfault,
    input  logic [3:0]  irq,
    input  logic [7:0]  cr_out,
    output logic        bank,
    output logic        cr_we,
    output logic [7:0]  cr_wdata,
    output logic        take_trap,
    output logic        ret_go,
    output logic [15:0] vector,
    output logic [2:0]  cause,
    output logic [15:0] epc,
    output logic [3:0]  irq_ack,
    output logic        halted
);

    typedef enum logic [2:0] {RUN, ENTER, SUPER, RESTORE, HALT} state_t;

    state_t      state_q, state_d;
    logic        pend_pf_q, pend_pf_d;
    logic        pend_swi_q, pend_swi_d;
    logic [7:0]  ucr_save_q, ucr_save_d;
    logic        bank_q, bank_d;
    logic        cr_we_q, cr_we_d;
    logic [7:0]  cr_wdata_q, cr_wdata_d;
    logic        take_trap_q, take_trap_d;
    logic        ret_go_q, ret_go_d;
    logic [15:0] vector_q, vector_d;
    logic [2:0]  cause_q, cause_d;
    logic [15:0] epc_q, epc_d;
    logic [3:0]  irq_ack_q, irq_ack_d;
    logic        halted_q, halted_d;

    logic        pf_pend;
    logic        swi_pend;
    logic [3:0]  irq_elig;
    logic        take;
    logic [2:0]  take_cause;

    always_comb begin
        pf_pend    = pend_pf_q | pfault;
        swi_pend   = pend_swi_q | swi;
        irq_elig   = irq & {4{cr_out[3]}};
        take       = 1'b0;
        take_cause = 3'd0;

        // A pending fault never waits for an instruction boundary; everything else does.
        if (pf_pend) begin
            take       = 1'b1;
            take_cause = 3'd0;
        end else if (instr_done) begin
            if (swi_pend) begin
                take       = 1'b1;
                take_cause = 3'd1;
            end else if (irq_elig[0]) begin
                take       = 1'b1;
                take_cause = 3'd2;
            end else if (irq_elig[1]) begin
                take       = 1'b1;
                take_cause = 3'd3;
            end else if (irq_elig[2]) begin
                take       = 1'b1;
                take_cause = 3'd4;
            end else if (irq_elig[3]) begin
                take       = 1'b1;
                take_cause = 3'd5;
            end
        end

        state_d     = state_q;
        pend_pf_d   = pf_pend;
        pend_swi_d  = swi_pend;
        ucr_save_d  = ucr_save_q;
        bank_d      = bank_q;
        cr_we_d     = 1'b0;
        cr_wdata_d  = cr_wdata_q;
        take_trap_d = 1'b0;
        ret_go_d    = 1'b0;
        vector_d    = vector_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        irq_ack_d   = 4'b0000;
        halted_d    = halted_q;

        // Outputs are computed for the state being entered so they are registered.
        case (state_q)
            RUN: begin
                bank_d = 1'b0;
                if (take) begin
                    state_d     = ENTER;
                    cause_d     = take_cause;
                    epc_d       = pc_in;
                    ucr_save_d  = cr_out;
                    vector_d    = VEC_BASE + {11'b0, take_cause, 2'b00};
                    bank_d      = 1'b1;
                    cr_we_d     = 1'b1;
                    cr_wdata_d  = 8'h01;
                    take_trap_d = 1'b1;
                    if (take_cause >= 3'd2) begin
                        irq_ack_d = 4'b0001 << (take_cause - 3'd2);
                    end
                    if (take_cause == 3'd0) begin
                        pend_pf_d = 1'b0;
                    end
                    if (take_cause == 3'd1) begin
                        pend_swi_d = 1'b0;
                    end
                end
            end
            ENTER: begin
                state_d = SUPER;
                bank_d  = 1'b1;
            end
            SUPER: begin
                bank_d = 1'b1;
                if (pfault) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else if (reti && instr_done) begin
                    state_d    = RESTORE;
                    bank_d     = 1'b0;
                    cr_we_d    = 1'b1;
                    cr_wdata_d = ucr_save_q;
                    ret_go_d   = 1'b1;
                end
            end
            RESTORE: begin
                state_d = RUN;
                bank_d  = 1'b0;
            end
            HALT: begin
                bank_d   = 1'b1;
                halted_d = 1'b1;
            end
            default: begin
                state_d = SUPER;
                bank_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SUPER;
            pend_pf_q   <= 1'b0;
            pend_swi_q  <= 1'b0;
            ucr_save_q  <= 8'h08;
            bank_q      <= 1'b1;
            cr_we_q     <= 1'b0;
            cr_wdata_q  <= 8'h00;
            take_trap_q <= 1'b0;
            ret_go_q    <= 1'b0;
            vector_q    <= VEC_BASE;
            cause_q     <= 3'd0;
            epc_q       <= 16'h0000;
            irq_ack_q   <= 4'b0000;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_pf_q   <= pend_pf_d;
            pend_swi_q  <= pend_swi_d;
            ucr_save_q  <= ucr_save_d;
            bank_q      <= bank_d;
            cr_we_q     <= cr_we_d;
            cr_wdata_q  <= cr_wdata_d;
            take_trap_q <= take_trap_d;
            ret_go_q    <= ret_go_d;
            vector_q    <= vector_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            irq_ack_q   <= irq_ack_d;
            halted_q    <= halted_d;
        end
    end

    assign bank      = bank_q;
    assign cr_we     = cr_we_q;
    assign cr_wdata  = cr_wdata_q;
    assign take_trap = take_trap_q;
    assign ret_go    = ret_go_q;
    assign vector    = vector_q;
    assign cause     = cause_q;
    assign epc       = epc_q;
    assign irq_ack   = irq_ack_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed vector table, hand-written corner sequences and
// randomized traffic checked against a mode-level reference model.
module tb_trap_sequencer;

    logic        clk;
    logic        reset;
    logic [15:0] pc_in;
    logic        instr_done;
    logic        reti;
    logic        swi;
    logic        pfault;
    logic [3:0]  irq;
    logic [7:0]  cr_out;
    logic        bank;
    logic        cr_we;
    logic [7:0]  cr_wdata;
    logic        take_trap;
    logic        ret_go;
    logic [15:0] vector;
    logic [2:0]  cause;
    logic [15:0] epc;
    logic [3:0]  irq_ack;
    logic        halted;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic        bank;
        logic        cr_we;
        logic [7:0]  wdata;
        logic        tt;
        logic        rg;
        logic [2:0]  cause;
        logic [15:0] vector;
        logic [15:0] epc;
        logic [3:0]  ack;
        logic        halted;
    } outs_t;

    typedef struct {
        logic        id;
        logic        rt;
        logic        sw;
        logic        pf;
        logic [3:0]  iq;
        logic [7:0]  cr;
        logic [15:0] pc;
        outs_t       exp;
    } vec_t;

    vec_t tbl[16];

    trap_sequencer #(.VEC_BASE(16'h0010)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .instr_done(instr_done),
        .reti(reti), .swi(swi), .pfault(pfault), .irq(irq), .cr_out(cr_out),
        .bank(bank), .cr_we(cr_we), .cr_wdata(cr_wdata), .take_trap(take_trap),
        .ret_go(ret_go), .vector(vector), .cause(cause), .epc(epc),
        .irq_ack(irq_ack), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t mk(logic b, logic we, logic [7:0] wd, logic tt, logic rg,
                                 logic [2:0] c, logic [15:0] v, logic [15:0] ep,
                                 logic [3:0] ak, logic h);
        outs_t o;
        o.bank = b; o.cr_we = we; o.wdata = wd; o.tt = tt; o.rg = rg;
        o.cause = c; o.vector = v; o.epc = ep; o.ack = ak; o.halted = h;
        return o;
    endfunction

    // Reference model: user/supervisor mode flags plus one-cycle entry/return pulses.
    bit          m_user, m_halt, m_enter, m_restore, m_pf, m_swi;
    int          m_cause;
    logic [15:0] m_epc;
    logic [7:0]  m_ucr;

    task automatic modelReset();
        m_user = 0; m_halt = 0; m_enter = 0; m_restore = 0; m_pf = 0; m_swi = 0;
        m_cause = 0; m_epc = 16'h0000; m_ucr = 8'h08;
    endtask

    task automatic modelStep(input logic id, input logic rt, input logic sw, input logic pf,
                             input logic [3:0] iq, input logic [7:0] cr, input logic [15:0] pc);
        bit pfp, swp;
        bit elig[6];
        int c;
        pfp = m_pf | pf;
        swp = m_swi | sw;
        if (m_halt) begin
        end else if (m_enter) begin
            m_enter = 0;
        end else if (m_restore) begin
            m_restore = 0;
        end else if (!m_user) begin
            if (pf) m_halt = 1;
            else if (rt && id) begin
                m_user = 1;
                m_restore = 1;
            end
        end else begin
            elig[0] = pfp;
            elig[1] = swp && id;
            for (int i = 0; i < 4; i++) elig[2+i] = iq[i] && cr[3] && id;
            c = -1;
            for (int k = 5; k >= 0; k--) if (elig[k]) c = k;
            if (c >= 0) begin
                m_cause = c; m_epc = pc; m_ucr = cr; m_user = 0; m_enter = 1;
                if (c == 0) pfp = 0;
                if (c == 1) swp = 0;
            end
        end
        m_pf = pfp;
        m_swi = swp;
    endtask

    function automatic outs_t modelExp();
        outs_t e;
        e.bank   = !m_user;
        e.cr_we  = m_enter || m_restore;
        e.wdata  = m_enter ? 8'h01 : m_ucr;
        e.tt     = m_enter;
        e.rg     = m_restore;
        e.cause  = 3'(m_cause);
        e.vector = 16'h0010 + 16'(4 * m_cause);
        e.epc    = m_epc;
        e.ack    = (m_enter && m_cause >= 2) ? 4'(1 << (m_cause - 2)) : 4'h0;
        e.halted = m_halt;
        return e;
    endfunction

    task automatic applyStimulus(input logic id, input logic rt, input logic sw, input logic pf,
                                 input logic [3:0] iq, input logic [7:0] cr, input logic [15:0] pc);
        instr_done = id; reti = rt; swi = sw; pfault = pf; irq = iq; cr_out = cr; pc_in = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input outs_t e);
        outs_t a, am, em;
        a = mk(bank, cr_we, cr_wdata, take_trap, ret_go, cause, vector, epc, irq_ack, halted);
        am = a;
        em = e;
        if (!e.cr_we) begin
            am.wdata = 8'h00;
            em.wdata = 8'h00;
        end
        checks++;
        if (am == em) passes++;
        else $display("[TB] FAIL %s: got bank=%0b we=%0b wd=%h tt=%0b rg=%0b cause=%0d vec=%h epc=%h ack=%b halt=%0b, want bank=%0b we=%0b wd=%h tt=%0b rg=%0b cause=%0d vec=%h epc=%h ack=%b halt=%0b",
                      name, a.bank, a.cr_we, a.wdata, a.tt, a.rg, a.cause, a.vector, a.epc, a.ack, a.halted,
                      e.bank, e.cr_we, e.wdata, e.tt, e.rg, e.cause, e.vector, e.epc, e.ack, e.halted);
    endtask

    task automatic idleInputs();
        instr_done = 0; reti = 0; swi = 0; pfault = 0; irq = 4'h0; cr_out = 8'h00; pc_in = 16'h0000;
    endtask

    initial begin
        outs_t rst_exp;
        int    halt_cycles;
        logic  r_id, r_rt, r_sw, r_pf;
        logic [3:0]  r_iq;
        logic [7:0]  r_cr;
        logic [15:0] r_pc;

        rst_exp = mk(1, 0, 8'h00, 0, 0, 3'd0, 16'h0010, 16'h0000, 4'h0, 0);
        idleInputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_state", rst_exp);
        reset = 1'b1;

        tbl[0]  = '{0, 0, 0, 0, 4'h0, 8'h00, 16'h0000, mk(1, 0, 8'h00, 0, 0, 3'd0, 16'h0010, 16'h0000, 4'h0, 0)};
        tbl[1]  = '{1, 1, 0, 0, 4'h0, 8'h00, 16'h0000, mk(0, 1, 8'h08, 0, 1, 3'd0, 16'h0010, 16'h0000, 4'h0, 0)};
        tbl[2]  = '{0, 0, 0, 0, 4'h0, 8'h00, 16'h0000, mk(0, 0, 8'h00, 0, 0, 3'd0, 16'h0010, 16'h0000, 4'h0, 0)};
        tbl[3]  = '{0, 0, 0, 0, 4'h4, 8'h0A, 16'h1234, mk(0, 0, 8'h00, 0, 0, 3'd0, 16'h0010, 16'h0000, 4'h0, 0)};
        tbl[4]  = '{1, 0, 0, 0, 4'h4, 8'h0A, 16'h1234, mk(1, 1, 8'h01, 1, 0, 3'd4, 16'h0020, 16'h1234, 4'h4, 0)};
        tbl[5]  = '{0, 0, 0, 0, 4'h0, 8'h01, 16'h0000, mk(1, 0, 8'h00, 0, 0, 3'd4, 16'h0020, 16'h1234, 4'h0, 0)};
        tbl[6]  = '{1, 1, 0, 0, 4'h0, 8'h01, 16'h0000, mk(0, 1, 8'h0A, 0, 1, 3'd4, 16'h0020, 16'h1234, 4'h0, 0)};
        tbl[7]  = '{0, 0, 0, 0, 4'h0, 8'h00, 16'h0000, mk(0, 0, 8'h00, 0, 0, 3'd4, 16'h0020, 16'h1234, 4'h0, 0)};
        tbl[8]  = '{0, 0, 1, 1, 4'h0, 8'h08, 16'h2000, mk(1, 1, 8'h01, 1, 0, 3'd0, 16'h0010, 16'h2000, 4'h0, 0)};
        tbl[9]  = '{0, 0, 0, 0, 4'h0, 8'h01, 16'h0000, mk(1, 0, 8'h00, 0, 0, 3'd0, 16'h0010, 16'h2000, 4'h0, 0)};
        tbl[10] = '{1, 1, 0, 0, 4'h0, 8'h01, 16'h0000, mk(0, 1, 8'h08, 0, 1, 3'd0, 16'h0010, 16'h2000, 4'h0, 0)};
        tbl[11] = '{0, 0, 0, 0, 4'h0, 8'h08, 16'h0000, mk(0, 0, 8'h00, 0, 0, 3'd0, 16'h0010, 16'h2000, 4'h0, 0)};
        tbl[12] = '{1, 0, 0, 0, 4'h0, 8'h08, 16'h3000, mk(1, 1, 8'h01, 1, 0, 3'd1, 16'h0014, 16'h3000, 4'h0, 0)};
        tbl[13] = '{0, 0, 0, 0, 4'h0, 8'h01, 16'h0000, mk(1, 0, 8'h00, 0, 0, 3'd1, 16'h0014, 16'h3000, 4'h0, 0)};
        tbl[14] = '{1, 1, 0, 0, 4'h0, 8'h01, 16'h0000, mk(0, 1, 8'h08, 0, 1, 3'd1, 16'h0014, 16'h3000, 4'h0, 0)};
        tbl[15] = '{0, 0, 0, 0, 4'h0, 8'h08, 16'h0000, mk(0, 0, 8'h00, 0, 0, 3'd1, 16'h0014, 16'h3000, 4'h0, 0)};

        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i].id, tbl[i].rt, tbl[i].sw, tbl[i].pf, tbl[i].iq, tbl[i].cr, tbl[i].pc);
            checkOutput($sformatf("table_row%0d", i), tbl[i].exp);
        end

        // Masked IRQs are ignored even at instruction boundaries, then taken once enabled.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 0, 0, 4'hF, 8'h00, 16'h4000);
            checkOutput("masked_irq", mk(0, 0, 8'h00, 0, 0, 3'd1, 16'h0014, 16'h3000, 4'h0, 0));
        end
        applyStimulus(1, 0, 0, 0, 4'hF, 8'h08, 16'h4000);
        checkOutput("unmasked_irq0", mk(1, 1, 8'h01, 1, 0, 3'd2, 16'h0018, 16'h4000, 4'h1, 0));
        applyStimulus(0, 0, 0, 0, 4'h0, 8'h01, 16'h0000);
        checkOutput("irq0_super", mk(1, 0, 8'h00, 0, 0, 3'd2, 16'h0018, 16'h4000, 4'h0, 0));

        // Fault together with reti in supervisor mode halts instead of returning.
        applyStimulus(1, 1, 0, 1, 4'h0, 8'h01, 16'h0000);
        checkOutput("double_fault", mk(1, 0, 8'h00, 0, 0, 3'd2, 16'h0018, 16'h4000, 4'h0, 1));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 1, 0, 4'hF, 8'h08, 16'h0000);
            checkOutput("halt_sticky", mk(1, 0, 8'h00, 0, 0, 3'd2, 16'h0018, 16'h4000, 4'h0, 1));
        end
        idleInputs();
        reset = 1'b0;
        #1;
        checkOutput("halt_reset", rst_exp);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 4'h0, 8'h00, 16'h0000);
        checkOutput("halt_recover", rst_exp);

        // Reset asserted between edges while the entry pulse is high.
        applyStimulus(1, 1, 0, 0, 4'h0, 8'h00, 16'h0000);
        applyStimulus(0, 0, 0, 0, 4'h0, 8'h00, 16'h0000);
        applyStimulus(1, 0, 0, 0, 4'h1, 8'h08, 16'h5000);
        checkOutput("enter_before_reset", mk(1, 1, 8'h01, 1, 0, 3'd2, 16'h0018, 16'h5000, 4'h1, 0));
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_enter", rst_exp);
        idleInputs();
        @(posedge clk);
        #1;
        reset = 1'b1;

        modelReset();
        halt_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if (halt_cycles > 3 || $urandom_range(0, 299) == 0) begin
                idleInputs();
                reset = 1'b0;
                #1;
                modelReset();
                checkOutput("random_reset", modelExp());
                @(posedge clk);
                #1;
                reset = 1'b1;
                halt_cycles = 0;
            end else begin
                r_id = ($urandom_range(0, 1) == 1);
                r_rt = ($urandom_range(0, 3) == 0);
                r_sw = ($urandom_range(0, 15) == 0);
                r_pf = ($urandom_range(0, 39) == 0);
                r_iq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                r_cr = 8'($urandom);
                r_pc = 16'($urandom);
                modelStep(r_id, r_rt, r_sw, r_pf, r_iq, r_cr, r_pc);
                applyStimulus(r_id, r_rt, r_sw, r_pf, r_iq, r_cr, r_pc);
                checkOutput("random", modelExp());
                if (m_halt) halt_cycles++;
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
